// File: rtl/fse_pkg.sv
// Shared constants and helpers for the fractionally-spaced equalizer and its
// LMS coefficient engine: word formats, tap count, FSM encoding, saturation.
package fse_pkg;

    localparam int NUM_TAPS  = 9;
    localparam int NBT_IN    = 8;     // S(8,7) input samples
    localparam int NBF_IN    = 7;
    localparam int NBT_Y     = 12;    // S(12,9) equalizer output / error
    localparam int NBF_Y     = 9;
    localparam int NBT_TAPS  = 28;    // S(28,25) taps
    localparam int NBF_TAPS  = 25;
    localparam int SLICE_LVL = 256;   // QPSK decision magnitude, 0.5 in S(12,9)
    localparam int KW        = $clog2(NUM_TAPS);

    // 1.0 in S(28,25): the centre-tap value after reset
    localparam logic signed [NBT_TAPS-1:0] TAP_ONE =
        {{(NBT_TAPS-NBF_TAPS-1){1'b0}}, 1'b1, {NBF_TAPS{1'b0}}};

    localparam logic signed [NBT_Y:0] SLICE_POS = (NBT_Y+1)'(SLICE_LVL);
    localparam logic signed [NBT_Y:0] SLICE_NEG = -SLICE_POS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_UPDATE,
        ST_COMMIT
    } lms_state_t;

    // Clamp an NBT_Y+1 bit difference back into S(12,9)
    function automatic logic signed [NBT_Y-1:0] sat_err(input logic signed [NBT_Y:0] v);
        if (v[NBT_Y] != v[NBT_Y-1])
            sat_err = v[NBT_Y] ? {1'b1, {(NBT_Y-1){1'b0}}} : {1'b0, {(NBT_Y-1){1'b1}}};
        else
            sat_err = v[NBT_Y-1:0];
    endfunction

endpackage

// File: rtl/fse_lms_adapt_if.sv
// Link between the FSE and the LMS engine: equalizer output with its baud
// strobe going one way, the packed tap bus with its load strobe going back.
interface fse_lms_adapt_if;
    import fse_pkg::*;

    logic signed [NBT_Y-1:0]        i_y_I;
    logic signed [NBT_Y-1:0]        i_y_Q;
    logic                           i_sym_valid;
    logic [NUM_TAPS*NBT_TAPS-1:0]   o_taps_I;
    logic [NUM_TAPS*NBT_TAPS-1:0]   o_taps_Q;
    logic                           o_en_taps;

    // FSE side
    modport master (
        output i_y_I, i_y_Q, i_sym_valid,
        input  o_taps_I, o_taps_Q, o_en_taps
    );

    // LMS engine side
    modport slave (
        input  i_y_I, i_y_Q, i_sym_valid,
        output o_taps_I, o_taps_Q, o_en_taps
    );
endinterface

// File: rtl/lms_tap_mac.sv
// Complex gradient for one tap: g = e * conj(x), scaled by mu and aligned to
// the tap format, then w - g saturated to S(28,25). Purely combinational;
// the top time-multiplexes it across the taps.
module lms_tap_mac
    import fse_pkg::*;
#(
    parameter int MU_SHIFT = 4
) (
    input  logic signed [NBT_Y-1:0]    e_i,
    input  logic signed [NBT_Y-1:0]    e_q,
    input  logic signed [NBT_IN-1:0]   x_i,
    input  logic signed [NBT_IN-1:0]   x_q,
    input  logic signed [NBT_TAPS-1:0] w_i,
    input  logic signed [NBT_TAPS-1:0] w_q,
    output logic signed [NBT_TAPS-1:0] w_i_next,
    output logic signed [NBT_TAPS-1:0] w_q_next
);
    localparam int PW  = NBT_Y + NBT_IN;               // S(20,16) products
    localparam int SW  = PW + 1;                       // S(21,16) sums
    localparam int LSH = NBF_TAPS - NBF_Y - NBF_IN;    // fraction alignment before mu
    localparam int GW  = SW + LSH;
    localparam int DW  = ((GW > NBT_TAPS) ? GW : NBT_TAPS) + 1;

    localparam logic signed [DW-1:0] TMAX = DW'((2**(NBT_TAPS-1)) - 1);
    localparam logic signed [DW-1:0] TMIN = -TMAX - DW'(1);

    logic signed [PW-1:0] p_ii, p_qq, p_qi, p_iq;
    logic signed [SW-1:0] g_i, g_q;
    logic signed [GW-1:0] g_i_al, g_q_al;
    logic signed [DW-1:0] d_i, d_q;

    assign p_ii = PW'(e_i) * PW'(x_i);
    assign p_qq = PW'(e_q) * PW'(x_q);
    assign p_qi = PW'(e_q) * PW'(x_i);
    assign p_iq = PW'(e_i) * PW'(x_q);

    assign g_i = SW'(p_ii) + SW'(p_qq);
    assign g_q = SW'(p_qi) - SW'(p_iq);

    // Left-align exactly, then the mu shift truncates toward -inf
    assign g_i_al = (GW'(g_i) <<< LSH) >>> MU_SHIFT;
    assign g_q_al = (GW'(g_q) <<< LSH) >>> MU_SHIFT;

    assign d_i = DW'(w_i) - DW'(g_i_al);
    assign d_q = DW'(w_q) - DW'(g_q_al);

    // Clamp the updated taps to the S(28,25) range
    always_comb begin
        w_i_next = d_i[NBT_TAPS-1:0];
        w_q_next = d_q[NBT_TAPS-1:0];
        if (d_i > TMAX)      w_i_next = TMAX[NBT_TAPS-1:0];
        else if (d_i < TMIN) w_i_next = TMIN[NBT_TAPS-1:0];
        if (d_q > TMAX)      w_q_next = TMAX[NBT_TAPS-1:0];
        else if (d_q < TMIN) w_q_next = TMIN[NBT_TAPS-1:0];
    end
endmodule

// File: rtl/fse_lms_adapt.sv
// Decision-directed LMS engine: snapshots the FSE output and a mirror of its
// delay line once per baud, slices to QPSK, forms the error and serially
// updates the taps, then strobes the new tap set back to the FSE.
module fse_lms_adapt
    import fse_pkg::*;
#(
    parameter int MU_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic signed [NBT_IN-1:0] i_is_data_I,
    input  logic signed [NBT_IN-1:0] i_is_data_Q,
    input  logic                     i_ctrl,
    input  logic                     i_en_rx,
    input  logic                     i_adapt_en,
    fse_lms_adapt_if.slave           bus,
    output logic signed [NBT_Y-1:0]  o_err_I,
    output logic signed [NBT_Y-1:0]  o_err_Q,
    output logic                     o_busy,
    output logic                     o_overrun
);
    lms_state_t state_reg, state_next;
    logic [KW-1:0] k_reg, k_next;

    logic signed [NBT_IN-1:0]   dl_i_reg   [NUM_TAPS];
    logic signed [NBT_IN-1:0]   dl_q_reg   [NUM_TAPS];
    logic signed [NBT_IN-1:0]   snap_i_reg [NUM_TAPS];
    logic signed [NBT_IN-1:0]   snap_q_reg [NUM_TAPS];
    logic signed [NBT_TAPS-1:0] w_i_reg    [NUM_TAPS];
    logic signed [NBT_TAPS-1:0] w_q_reg    [NUM_TAPS];
    logic signed [NBT_Y-1:0]    y_i_reg, y_q_reg;
    logic signed [NBT_Y-1:0]    err_i_reg, err_q_reg;
    logic                       overrun_reg;

    logic signed [NBT_Y:0]      diff_i, diff_q;
    logic signed [NBT_TAPS-1:0] w_i_next, w_q_next;

    // Slicer and error on the snapshot; only registered in LATCH
    assign diff_i = (NBT_Y+1)'(y_i_reg) - (y_i_reg[NBT_Y-1] ? SLICE_NEG : SLICE_POS);
    assign diff_q = (NBT_Y+1)'(y_q_reg) - (y_q_reg[NBT_Y-1] ? SLICE_NEG : SLICE_POS);

    lms_tap_mac #(.MU_SHIFT(MU_SHIFT)) u_mac (
        .e_i      (err_i_reg),
        .e_q      (err_q_reg),
        .x_i      (snap_i_reg[k_reg]),
        .x_q      (snap_q_reg[k_reg]),
        .w_i      (w_i_reg[k_reg]),
        .w_q      (w_q_reg[k_reg]),
        .w_i_next (w_i_next),
        .w_q_next (w_q_next)
    );

    // State and tap-index register
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
        end else if (!i_en_rx) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
        end
    end

    // Next-state logic: capture only from IDLE, walk k across the taps
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        case (state_reg)
            ST_IDLE:   if (bus.i_sym_valid) state_next = ST_LATCH;
            ST_LATCH: begin
                k_next     = '0;
                state_next = i_adapt_en ? ST_UPDATE : ST_IDLE;
            end
            ST_UPDATE: begin
                if (k_reg == KW'(NUM_TAPS-1)) begin
                    k_next     = '0;
                    state_next = ST_COMMIT;
                end else begin
                    k_next = k_reg + KW'(1);
                end
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Mirror delay line (index 0 newest), snapshot, error, taps, overrun flag
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset || !i_en_rx) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                dl_i_reg[j]   <= '0;
                dl_q_reg[j]   <= '0;
                snap_i_reg[j] <= '0;
                snap_q_reg[j] <= '0;
                w_i_reg[j]    <= (j == NUM_TAPS/2) ? TAP_ONE : '0;
                w_q_reg[j]    <= '0;
            end
            y_i_reg     <= '0;
            y_q_reg     <= '0;
            err_i_reg   <= '0;
            err_q_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (i_ctrl) begin
                dl_i_reg[0] <= i_is_data_I;
                dl_q_reg[0] <= i_is_data_Q;
                for (int j = 1; j < NUM_TAPS; j++) begin
                    dl_i_reg[j] <= dl_i_reg[j-1];
                    dl_q_reg[j] <= dl_q_reg[j-1];
                end
            end
            if (state_reg == ST_IDLE && bus.i_sym_valid) begin
                snap_i_reg <= dl_i_reg;
                snap_q_reg <= dl_q_reg;
                y_i_reg    <= bus.i_y_I;
                y_q_reg    <= bus.i_y_Q;
            end
            if (state_reg == ST_LATCH) begin
                err_i_reg <= sat_err(diff_i);
                err_q_reg <= sat_err(diff_q);
            end
            if (state_reg == ST_UPDATE) begin
                w_i_reg[k_reg] <= w_i_next;
                w_q_reg[k_reg] <= w_q_next;
            end
            overrun_reg <= bus.i_sym_valid && (state_reg != ST_IDLE);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_pack
            assign bus.o_taps_I[gi*NBT_TAPS +: NBT_TAPS] = w_i_reg[gi];
            assign bus.o_taps_Q[gi*NBT_TAPS +: NBT_TAPS] = w_q_reg[gi];
        end
    endgenerate

    assign bus.o_en_taps = (state_reg == ST_COMMIT);
    assign o_busy        = (state_reg != ST_IDLE);
    assign o_overrun     = overrun_reg;
    assign o_err_I       = err_i_reg;
    assign o_err_Q       = err_q_reg;
endmodule

// File: tb/tb_fse_lms_adapt.sv
// Directed + randomized bench for fse_lms_adapt against an arithmetic model
// of the LMS update rules.
module tb_fse_lms_adapt;
    import fse_pkg::*;

    localparam int MU = 4;
    localparam int NT = NUM_TAPS;
    localparam int BW = NUM_TAPS * NBT_TAPS;
    localparam longint TAP_MAX = (64'sd1 <<< (NBT_TAPS-1)) - 1;
    localparam longint TAP_MIN = -(64'sd1 <<< (NBT_TAPS-1));

    logic clk = 1'b0;
    logic i_reset;
    logic signed [NBT_IN-1:0] i_is_data_I, i_is_data_Q;
    logic i_ctrl, i_en_rx, i_adapt_en;
    logic signed [NBT_Y-1:0] o_err_I, o_err_Q;
    logic o_busy, o_overrun;

    fse_lms_adapt_if bus();

    fse_lms_adapt #(.MU_SHIFT(MU)) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_is_data_I (i_is_data_I),
        .i_is_data_Q (i_is_data_Q),
        .i_ctrl      (i_ctrl),
        .i_en_rx     (i_en_rx),
        .i_adapt_en  (i_adapt_en),
        .bus         (bus),
        .o_err_I     (o_err_I),
        .o_err_Q     (o_err_Q),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    longint m_wi[NT], m_wq[NT];
    int     m_xi[NT], m_xq[NT];
    int     m_ei, m_eq;

    function automatic void model_reset();
        for (int j = 0; j < NT; j++) begin
            m_wi[j] = (j == NT/2) ? (64'sd1 <<< NBF_TAPS) : 0;
            m_wq[j] = 0;
            m_xi[j] = 0;
            m_xq[j] = 0;
        end
        m_ei = 0;
        m_eq = 0;
    endfunction

    function automatic void model_shift(int xi, int xq);
        for (int j = NT-1; j > 0; j--) begin
            m_xi[j] = m_xi[j-1];
            m_xq[j] = m_xq[j-1];
        end
        m_xi[0] = xi;
        m_xq[0] = xq;
    endfunction

    function automatic int slice_err(int y);
        int e;
        e = y - ((y >= 0) ? SLICE_LVL : -SLICE_LVL);
        if (e > 2047) e = 2047;
        if (e < -2048) e = -2048;
        return e;
    endfunction

    // Scale a gradient into tap units: multiply by 2^a, or floor-divide
    function automatic longint align(longint g);
        int a;
        longint d;
        a = NBF_TAPS - NBF_Y - NBF_IN - MU;
        if (a >= 0) return g * (64'sd1 <<< a);
        d = 64'sd1 <<< (-a);
        return (g - (((g % d) + d) % d)) / d;
    endfunction

    function automatic longint sat_tap(longint v);
        if (v > TAP_MAX) return TAP_MAX;
        if (v < TAP_MIN) return TAP_MIN;
        return v;
    endfunction

    function automatic void model_sym(int yi, int yq, bit adapt, int sxi[NT], int sxq[NT]);
        longint gi, gq;
        m_ei = slice_err(yi);
        m_eq = slice_err(yq);
        if (adapt) begin
            for (int k = 0; k < NT; k++) begin
                gi = longint'(m_ei) * sxi[k] + longint'(m_eq) * sxq[k];
                gq = longint'(m_eq) * sxi[k] - longint'(m_ei) * sxq[k];
                m_wi[k] = sat_tap(m_wi[k] - align(gi));
                m_wq[k] = sat_tap(m_wq[k] - align(gq));
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_taps(input string tag);
        logic [BW-1:0] ei, eq;
        for (int j = 0; j < NT; j++) begin
            ei[j*NBT_TAPS +: NBT_TAPS] = m_wi[j][NBT_TAPS-1:0];
            eq[j*NBT_TAPS +: NBT_TAPS] = m_wq[j][NBT_TAPS-1:0];
        end
        checks++;
        assert (bus.o_taps_I === ei) else begin
            errors++;
            $error("FAIL %s_I: observed=%h expected=%h", tag, bus.o_taps_I, ei);
        end
        checks++;
        assert (bus.o_taps_Q === eq) else begin
            errors++;
            $error("FAIL %s_Q: observed=%h expected=%h", tag, bus.o_taps_Q, eq);
        end
    endtask

    task automatic shift_in(input int xi, input int xq);
        i_is_data_I = NBT_IN'(xi);
        i_is_data_Q = NBT_IN'(xq);
        i_ctrl = 1'b1;
        tick();
        i_ctrl = 1'b0;
        model_shift(int'(i_is_data_I), int'(i_is_data_Q));
    endtask

    task automatic clear_rx();
        i_en_rx = 1'b0;
        tick();
        i_en_rx = 1'b1;
        model_reset();
    endtask

    // One baud strobe at window cycle 0 (optionally a second at second_at),
    // observed for 20 cycles; the model updates from the captured line.
    task automatic run_sym(input int yi, input int yq, input bit adapt, input int second_at,
                           input bit noisy, output int en_cnt, output int en_first,
                           output int busy_cnt, output int ov_cnt);
        int sxi[NT], sxq[NT];
        sxi = m_xi;
        sxq = m_xq;
        en_cnt = 0; en_first = -1; busy_cnt = 0; ov_cnt = 0;
        i_adapt_en = adapt;
        for (int i = 0; i < 20; i++) begin
            bus.i_sym_valid = (i == 0) || (i == second_at);
            if (i == 0) begin
                bus.i_y_I = NBT_Y'(yi);
                bus.i_y_Q = NBT_Y'(yq);
            end else if (noisy) begin
                bus.i_y_I = NBT_Y'($urandom);
                bus.i_y_Q = NBT_Y'($urandom);
            end
            if (noisy && i > 0) begin
                i_is_data_I = NBT_IN'($urandom);
                i_is_data_Q = NBT_IN'($urandom);
                i_ctrl = 1'b1;
            end else begin
                i_ctrl = 1'b0;
            end
            tick();
            if (i_ctrl) model_shift(int'(i_is_data_I), int'(i_is_data_Q));
            if (bus.o_en_taps) begin
                en_cnt++;
                if (en_first < 0) en_first = i + 1;
            end
            if (o_busy) busy_cnt++;
            if (o_overrun) ov_cnt++;
        end
        bus.i_sym_valid = 1'b0;
        i_ctrl = 1'b0;
        model_sym(yi, yq, adapt, sxi, sxq);
    endtask

    initial begin
        int en_cnt, en_first, busy_cnt, ov_cnt;
        int yi, yq;

        i_reset = 1'b1; i_en_rx = 1'b1; i_adapt_en = 1'b1; i_ctrl = 1'b0;
        i_is_data_I = '0; i_is_data_Q = '0;
        bus.i_y_I = '0; bus.i_y_Q = '0; bus.i_sym_valid = 1'b0;
        model_reset();
        tick(); tick(); tick();
        i_reset = 1'b0;
        tick();

        // Reset state
        check_taps("rst_taps");
        check("rst_tap4", $signed(bus.o_taps_I[4*NBT_TAPS +: NBT_TAPS]), 33554432);
        check("rst_en_taps", bus.o_en_taps, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err_I", o_err_I, 0);
        $display("reset: taps/err/strobes checked");

        // Single update: only the centre regressor is non-zero
        for (int j = NT-1; j >= 0; j--) shift_in((j == 4) ? 64 : 0, 0);
        run_sym(384, 256, 1'b1, -1, 1'b0, en_cnt, en_first, busy_cnt, ov_cnt);
        check("single_err_I", o_err_I, 128);
        check("single_err_Q", o_err_Q, 0);
        check("single_en_cnt", en_cnt, 1);
        check("single_latency", en_first, 11);
        check("single_busy", busy_cnt, 11);
        check("single_tap4", $signed(bus.o_taps_I[4*NBT_TAPS +: NBT_TAPS]), 33292288);
        check_taps("single_taps");
        $display("single update: err=%0d,%0d en_first=%0d", o_err_I, o_err_Q, en_first);

        // Zero error: decisions exact, taps must not move
        run_sym(256, -256, 1'b1, -1, 1'b0, en_cnt, en_first, busy_cnt, ov_cnt);
        check("zero_err_I", o_err_I, 0);
        check("zero_err_Q", o_err_Q, 0);
        check("zero_en_cnt", en_cnt, 1);
        check_taps("zero_taps");
        $display("zero error: en_cnt=%0d", en_cnt);

        // Overrun: second strobe three cycles in is dropped
        clear_rx();
        check_taps("clear_taps");
        for (int j = NT-1; j >= 0; j--) shift_in((j == 4) ? 64 : 0, 0);
        run_sym(384, 256, 1'b1, 3, 1'b0, en_cnt, en_first, busy_cnt, ov_cnt);
        check("ovr_pulses", ov_cnt, 1);
        check("ovr_en_cnt", en_cnt, 1);
        check("ovr_tap4", $signed(bus.o_taps_I[4*NBT_TAPS +: NBT_TAPS]), 33292288);
        check_taps("ovr_taps");
        $display("overrun: ov_cnt=%0d en_cnt=%0d", ov_cnt, en_cnt);

        // Freeze: error still computed, no update and no strobe
        run_sym(384, 256, 1'b0, -1, 1'b0, en_cnt, en_first, busy_cnt, ov_cnt);
        check("frz_err_I", o_err_I, 128);
        check("frz_en_cnt", en_cnt, 0);
        check("frz_busy", busy_cnt, 1);
        check_taps("frz_taps");
        $display("freeze: busy_cnt=%0d en_cnt=%0d", busy_cnt, en_cnt);

        // Random regressors and outputs; line and y keep changing while busy
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < NT; j++)
                shift_in(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
            yi = int'($urandom_range(4095)) - 2048;
            yq = int'($urandom_range(4095)) - 2048;
            run_sym(yi, yq, 1'b1, -1, 1'b1, en_cnt, en_first, busy_cnt, ov_cnt);
            check("rnd_err_I", o_err_I, m_ei);
            check("rnd_err_Q", o_err_Q, m_eq);
            check("rnd_latency", en_first, 11);
            check_taps("rnd_taps");
            $display("random %0d: y=%0d,%0d err=%0d,%0d", r, yi, yq, o_err_I, o_err_Q);
        end

        // Saturation: repeated negative gradients drive taps to +max
        clear_rx();
        for (int j = 0; j < NT; j++) shift_in(-128, -128);
        for (int r = 0; r < 10; r++)
            run_sym(2047, 2047, 1'b1, -1, 1'b0, en_cnt, en_first, busy_cnt, ov_cnt);
        check("sat_tap0", $signed(bus.o_taps_I[0 +: NBT_TAPS]), TAP_MAX);
        check_taps("sat_taps");
        $display("saturation: tap0=%0d", $signed(bus.o_taps_I[0 +: NBT_TAPS]));

        // Receiver disable in the middle of UPDATE discards the update
        bus.i_sym_valid = 1'b1;
        bus.i_y_I = NBT_Y'(2047);
        bus.i_y_Q = NBT_Y'(2047);
        tick();
        bus.i_sym_valid = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.o_en_taps) en_cnt++;
        end
        check("mid_busy_before", o_busy, 1);
        i_en_rx = 1'b0;
        tick();
        i_en_rx = 1'b1;
        model_reset();
        check_taps("mid_taps");
        check("mid_busy", o_busy, 0);
        check("mid_err_I", o_err_I, 0);
        for (int i = 0; i < 15; i++) begin
            if (bus.o_en_taps) en_cnt++;
            tick();
        end
        check("mid_en_cnt", en_cnt, 0);
        check_taps("mid_taps_after");
        $display("mid-update clear: en_cnt=%0d", en_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
